// File: rtl/ik_pkg.sv
// Shared types for the inverse-kinematics angle capture block: default widths,
// settle FSM states and the default-width result entry.
package ik_pkg;

    localparam int unsigned DEFAULT_BIT_WIDTH = 32;
    localparam int unsigned DEFAULT_FRACTIONS = 15;

    typedef enum logic {
        StIdle = 1'b0,
        StWait = 1'b1
    } ik_state_e;

    typedef struct packed {
        logic [DEFAULT_BIT_WIDTH-1:0] theta1;
        logic [DEFAULT_BIT_WIDTH-1:0] theta2;
        logic                         timeout;
    } ik_entry_t;

endpackage

// File: rtl/ik_angle_capture_if.sv
// Result stream of the angle capture block: FWFT head plus valid/ready handshake.
interface ik_angle_capture_if
    import ik_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = DEFAULT_BIT_WIDTH
) ();

    logic                 out_valid;
    logic                 out_ready;
    logic [BIT_WIDTH-1:0] out_theta1;
    logic [BIT_WIDTH-1:0] out_theta2;
    logic                 out_timeout;

    modport master (
        output out_valid,
        output out_theta1,
        output out_theta2,
        output out_timeout,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_theta1,
        input  out_theta2,
        input  out_timeout,
        output out_ready
    );

endinterface

// File: rtl/ik_result_fifo.sv
// First-word-fall-through result buffer. A push into a full buffer is accepted
// only when a pop happens in the same cycle; the head holds its last value when empty.
module ik_result_fifo
    import ik_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = ik_entry_t
) (
    input  logic   clock,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    entry_t           mem [DEPTH];
    entry_t           hold_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Empty buffer shows the last head seen so consumers never observe glitching data.
    assign head    = empty ? hold_q : mem[rd_ptr_q];

    always_ff @(posedge clock) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            hold_q <= head;
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !rst) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/ik_angle_capture.sv
// Waits for the inverse-kinematics outputs to settle after each new target and
// buffers the settled (or timed-out) joint angle pair for a downstream consumer.
module ik_angle_capture
    import ik_pkg::*;
#(
    parameter int unsigned BIT_WIDTH      = DEFAULT_BIT_WIDTH,
    parameter int unsigned FRACTIONS      = DEFAULT_FRACTIONS,
    parameter int unsigned STABLE_CYCLES  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BIT_WIDTH-1:0] theta1_in,
    input  logic [BIT_WIDTH-1:0] theta2_in,
    output logic                 busy,
    output logic                 overflow,
    ik_angle_capture_if.master   res
);

    localparam int unsigned     EL_W           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]      STABLE_TARGET  = 8'(STABLE_CYCLES);
    localparam logic [EL_W-1:0] TIMEOUT_TARGET = EL_W'(TIMEOUT_CYCLES);

    if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255 || TIMEOUT_CYCLES <= STABLE_CYCLES ||
        FRACTIONS >= BIT_WIDTH) begin : g_param_check
        $error("ik_angle_capture: illegal parameter combination");
    end

    // Same shape as ik_entry_t, widened to this instance's angle width.
    typedef struct packed {
        logic [BIT_WIDTH-1:0] theta1;
        logic [BIT_WIDTH-1:0] theta2;
        logic                 timeout;
    } entry_t;

    ik_state_e            state_q, state_d;
    logic [BIT_WIDTH-1:0] prev_t1_q, prev_t1_d;
    logic [BIT_WIDTH-1:0] prev_t2_q, prev_t2_d;
    logic [7:0]           stable_cnt_q, stable_cnt_d;
    logic [EL_W-1:0]      elapsed_q, elapsed_d;
    logic                 overflow_q, overflow_d;
    logic                 match;
    logic                 stable_hit;
    logic                 timeout_hit;
    logic                 push;
    entry_t               push_data;
    entry_t               fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;

    assign match = (theta1_in == prev_t1_q) && (theta2_in == prev_t2_q);

    always_comb begin
        state_d      = state_q;
        prev_t1_d    = prev_t1_q;
        prev_t2_d    = prev_t2_q;
        stable_cnt_d = stable_cnt_q;
        elapsed_d    = elapsed_q;
        stable_hit   = 1'b0;
        timeout_hit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d      = StWait;
                    prev_t1_d    = theta1_in;
                    prev_t2_d    = theta2_in;
                    stable_cnt_d = '0;
                    elapsed_d    = '0;
                end
            end
            StWait: begin
                prev_t1_d    = theta1_in;
                prev_t2_d    = theta2_in;
                elapsed_d    = elapsed_q + 1'b1;
                stable_cnt_d = match ? stable_cnt_q + 1'b1 : '0;
                stable_hit   = match && (stable_cnt_d == STABLE_TARGET);
                timeout_hit  = (elapsed_d == TIMEOUT_TARGET);
                // A new target restarts the window; any capture this cycle still pushes.
                if (start) begin
                    stable_cnt_d = '0;
                    elapsed_d    = '0;
                end else if (stable_hit || timeout_hit) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign push              = stable_hit || timeout_hit;
    assign push_data.theta1  = theta1_in;
    assign push_data.theta2  = theta2_in;
    assign push_data.timeout = !stable_hit;

    // Full implies non-empty, so out_ready alone tells whether a pop frees a slot.
    assign overflow_d = overflow_q || (push && fifo_full && !res.out_ready);

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q      <= StIdle;
            prev_t1_q    <= '0;
            prev_t2_q    <= '0;
            stable_cnt_q <= '0;
            elapsed_q    <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_t1_q    <= prev_t1_d;
            prev_t2_q    <= prev_t2_d;
            stable_cnt_q <= stable_cnt_d;
            elapsed_q    <= elapsed_d;
            overflow_q   <= overflow_d;
        end
    end

    ik_result_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clock     (clock),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (res.out_ready),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign busy            = (state_q == StWait);
    assign overflow        = overflow_q;
    assign res.out_valid   = !fifo_empty;
    assign res.out_theta1  = fifo_head.theta1;
    assign res.out_theta2  = fifo_head.theta2;
    assign res.out_timeout = fifo_head.timeout;

endmodule

// File: tb/tb_ik_angle_capture.sv
// Self-checking bench for ik_angle_capture: directed scenarios plus a randomized
// run scored against a window/queue reference model.
module tb_ik_angle_capture;

    localparam int STABLE  = 8;
    localparam int TIMEOUT = 1024;
    localparam int DEPTH   = 4;
    localparam int RN      = 400;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          to;
    } m_entry_t;

    logic        clock;
    logic        rst;
    logic        start;
    logic [31:0] theta1_in;
    logic [31:0] theta2_in;
    logic        busy;
    logic        overflow;
    int          checks;
    int          failures;

    ik_angle_capture_if #(.BIT_WIDTH(32)) res ();

    ik_angle_capture #(
        .BIT_WIDTH      (32),
        .FRACTIONS      (15),
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .start     (start),
        .theta1_in (theta1_in),
        .theta2_in (theta2_in),
        .busy      (busy),
        .overflow  (overflow),
        .res       (res)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; res.out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic settle_capture(input logic [31:0] a, input logic [31:0] b);
        theta1_in = a; theta2_in = b; start = 1'b1;
        step();
        start = 1'b0;
        repeat (STABLE) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; res.out_ready = 1'b1;
        theta1_in = $urandom; theta2_in = $urandom;
        step(); step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (res.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", res.out_valid); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
        checks++; if (res.out_theta1 !== 32'h0 || res.out_theta2 !== 32'h0 || res.out_timeout !== 1'b0) begin
            failures++; $display("FAIL reset_head got=%h/%h/%0b exp=0/0/0", res.out_theta1, res.out_theta2, res.out_timeout);
        end
        rst = 1'b0; start = 1'b0; res.out_ready = 1'b0;
    endtask

    task automatic test_settled();
        do_reset();
        theta1_in = 32'h0000C90F; theta2_in = 32'h00006488; start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL settled_busy got=%0b exp=1", busy); end
        repeat (STABLE - 1) step();
        checks++; if (res.out_valid !== 1'b0) begin failures++; $display("FAIL settled_early got=%0b exp=0", res.out_valid); end
        step();
        checks++; if (res.out_valid !== 1'b1) begin failures++; $display("FAIL settled_valid got=%0b exp=1", res.out_valid); end
        checks++; if (res.out_theta1 !== 32'h0000C90F || res.out_theta2 !== 32'h00006488 || res.out_timeout !== 1'b0) begin
            failures++; $display("FAIL settled_head got=%h/%h/%0b exp=0000c90f/00006488/0", res.out_theta1, res.out_theta2, res.out_timeout);
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL settled_idle got=%0b exp=0", busy); end
    endtask

    task automatic test_late_change();
        logic [31:0] a, b;
        do_reset();
        a = $urandom; b = $urandom;
        theta1_in = a; theta2_in = b; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        theta1_in = a ^ 32'h5; theta2_in = b + 32'd3;
        repeat (STABLE) step();
        checks++; if (res.out_valid !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL late_early got=valid%0b/busy%0b exp=valid0/busy1", res.out_valid, busy);
        end
        step();
        checks++; if (res.out_valid !== 1'b1) begin failures++; $display("FAIL late_valid got=%0b exp=1", res.out_valid); end
        checks++; if (res.out_theta1 !== (a ^ 32'h5) || res.out_theta2 !== (b + 32'd3)) begin
            failures++; $display("FAIL late_head got=%h/%h exp=%h/%h", res.out_theta1, res.out_theta2, a ^ 32'h5, b + 32'd3);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] b;
        do_reset();
        b = $urandom;
        theta1_in = 32'h1; theta2_in = b; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < TIMEOUT; c++) begin
            theta1_in = (c % 2 == 0) ? 32'h1 : 32'h2;
            step();
        end
        checks++; if (res.out_valid !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL timeout_early got=valid%0b/busy%0b exp=valid0/busy1", res.out_valid, busy);
        end
        theta1_in = 32'h1;
        step();
        checks++; if (res.out_valid !== 1'b1 || res.out_timeout !== 1'b1) begin
            failures++; $display("FAIL timeout_push got=valid%0b/to%0b exp=valid1/to1", res.out_valid, res.out_timeout);
        end
        checks++; if (res.out_theta1 !== 32'h1 || res.out_theta2 !== b) begin
            failures++; $display("FAIL timeout_head got=%h/%h exp=00000001/%h", res.out_theta1, res.out_theta2, b);
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_restart();
        logic [31:0] a, b, c;
        do_reset();
        a = $urandom; b = $urandom; c = a + 32'd77;
        theta1_in = a; theta2_in = b; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (STABLE - 1) step();
        checks++; if (res.out_valid !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL restart_early got=valid%0b/busy%0b exp=valid0/busy1", res.out_valid, busy);
        end
        step();
        checks++; if (res.out_valid !== 1'b1 || res.out_theta1 !== a) begin
            failures++; $display("FAIL restart_push got=valid%0b/%h exp=valid1/%h", res.out_valid, res.out_theta1, a);
        end
        // Start coinciding with a capture: push completes and a new window opens.
        theta1_in = c; start = 1'b1;
        step();
        start = 1'b0;
        repeat (STABLE - 1) step();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_on_capture_busy got=%0b exp=1", busy); end
        repeat (STABLE) step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start_on_capture_done got=%0b exp=0", busy); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (res.out_valid !== 1'b1 || res.out_theta1 !== ((i == 0) ? a : c)) begin
                failures++; $display("FAIL restart_drain%0d got=valid%0b/%h exp=valid1/%h", i, res.out_valid, res.out_theta1, (i == 0) ? a : c);
            end
            res.out_ready = 1'b1; step(); res.out_ready = 1'b0;
        end
        checks++; if (res.out_valid !== 1'b0) begin failures++; $display("FAIL restart_empty got=%0b exp=0", res.out_valid); end
    endtask

    task automatic test_overflow();
        logic [31:0] v1 [5];
        logic [31:0] v2 [5];
        do_reset();
        for (int i = 0; i < 5; i++) begin
            v1[i] = $urandom; v2[i] = $urandom;
            settle_capture(v1[i], v2[i]);
        end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_set got=%0b exp=1", overflow); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (res.out_valid !== 1'b1 || res.out_theta1 !== v1[i] || res.out_theta2 !== v2[i]) begin
                failures++; $display("FAIL overflow_entry%0d got=valid%0b/%h/%h exp=valid1/%h/%h", i, res.out_valid, res.out_theta1, res.out_theta2, v1[i], v2[i]);
            end
            res.out_ready = 1'b1; step(); res.out_ready = 1'b0;
        end
        checks++; if (res.out_valid !== 1'b0) begin failures++; $display("FAIL overflow_dropped got=%0b exp=0", res.out_valid); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_sticky got=%0b exp=1", overflow); end
    endtask

    task automatic test_full_pop_push();
        logic [31:0] v1 [5];
        logic [31:0] v2 [5];
        do_reset();
        for (int i = 0; i < 5; i++) begin
            v1[i] = $urandom; v2[i] = $urandom;
        end
        for (int i = 0; i < DEPTH; i++) settle_capture(v1[i], v2[i]);
        theta1_in = v1[4]; theta2_in = v2[4]; start = 1'b1;
        step();
        start = 1'b0;
        repeat (STABLE - 1) step();
        res.out_ready = 1'b1; step(); res.out_ready = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fullpp_overflow got=%0b exp=0", overflow); end
        for (int i = 1; i <= DEPTH; i++) begin
            checks++; if (res.out_valid !== 1'b1 || res.out_theta1 !== v1[i] || res.out_theta2 !== v2[i]) begin
                failures++; $display("FAIL fullpp_entry%0d got=valid%0b/%h/%h exp=valid1/%h/%h", i, res.out_valid, res.out_theta1, res.out_theta2, v1[i], v2[i]);
            end
            res.out_ready = 1'b1; step(); res.out_ready = 1'b0;
        end
        checks++; if (res.out_valid !== 1'b0) begin failures++; $display("FAIL fullpp_empty got=%0b exp=0", res.out_valid); end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        theta1_in = 32'h0000C90F; theta2_in = 32'h00006488; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        rst = 1'b1; step(); rst = 1'b0;
        checks++; if (busy !== 1'b0 || res.out_valid !== 1'b0) begin
            failures++; $display("FAIL rstwait_abort got=busy%0b/valid%0b exp=busy0/valid0", busy, res.out_valid);
        end
        repeat (12) step();
        checks++; if (res.out_valid !== 1'b0) begin failures++; $display("FAIL rstwait_nopush got=%0b exp=0", res.out_valid); end
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (STABLE - 1) step();
        checks++; if (res.out_valid !== 1'b0) begin failures++; $display("FAIL rstwait_early got=%0b exp=0", res.out_valid); end
        step();
        checks++; if (res.out_valid !== 1'b1 || res.out_theta1 !== 32'h0000C90F || res.out_theta2 !== 32'h00006488 || res.out_timeout !== 1'b0) begin
            failures++; $display("FAIL rstwait_capture got=valid%0b/%h/%h/%0b exp=valid1/0000c90f/00006488/0", res.out_valid, res.out_theta1, res.out_theta2, res.out_timeout);
        end
    endtask

    task automatic test_random();
        logic [31:0] s1 [RN];
        logic [31:0] s2 [RN];
        bit          st [RN];
        bit          rdy [RN];
        m_entry_t    q [$];
        m_entry_t    e;
        int          win;
        bit          ovf, pushed, stable, pop;
        do_reset();
        for (int c = 0; c < RN; c++) begin
            s1[c]  = (c == 0 || $urandom_range(5) == 0) ? 32'($urandom_range(3)) : s1[c-1];
            s2[c]  = (c == 0 || $urandom_range(9) == 0) ? 32'($urandom_range(2)) : s2[c-1];
            st[c]  = ($urandom_range(24) == 0);
            rdy[c] = ($urandom_range(2) == 0);
        end
        win = -1; ovf = 1'b0;
        for (int c = 0; c < RN; c++) begin
            theta1_in = s1[c]; theta2_in = s2[c]; start = st[c]; res.out_ready = rdy[c];
            step();
            // A window captures once the last STABLE+1 samples since its start are identical.
            pushed = 1'b0; stable = 1'b0;
            if (win >= 0) begin
                if (c - win >= STABLE) begin
                    stable = 1'b1;
                    for (int k = c - STABLE; k < c; k++)
                        if (s1[k] !== s1[c] || s2[k] !== s2[c]) stable = 1'b0;
                end
                pushed = stable || (c - win == TIMEOUT);
                if (st[c]) win = c;
                else if (pushed) win = -1;
            end else if (st[c]) begin
                win = c;
            end
            pop = rdy[c] && (q.size() > 0);
            if (pushed && q.size() == DEPTH && !pop) ovf = 1'b1;
            if (pop) void'(q.pop_front());
            if (pushed && q.size() < DEPTH) begin
                e.a = s1[c]; e.b = s2[c]; e.to = !stable;
                q.push_back(e);
            end
            checks++; if (res.out_valid !== (q.size() > 0)) begin
                failures++; $display("FAIL rand_valid c=%0d got=%0b exp=%0b", c, res.out_valid, q.size() > 0);
            end
            checks++; if (busy !== (win >= 0)) begin
                failures++; $display("FAIL rand_busy c=%0d got=%0b exp=%0b", c, busy, win >= 0);
            end
            checks++; if (overflow !== ovf) begin
                failures++; $display("FAIL rand_overflow c=%0d got=%0b exp=%0b", c, overflow, ovf);
            end
            if (q.size() > 0) begin
                checks++; if (res.out_theta1 !== q[0].a || res.out_theta2 !== q[0].b || res.out_timeout !== q[0].to) begin
                    failures++; $display("FAIL rand_head c=%0d got=%h/%h/%0b exp=%h/%h/%0b", c, res.out_theta1, res.out_theta2, res.out_timeout, q[0].a, q[0].b, q[0].to);
                end
            end
        end
        start = 1'b0; res.out_ready = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; start = 1'b0; res.out_ready = 1'b0;
        theta1_in = '0; theta2_in = '0;
        test_reset();
        test_settled();
        test_late_change();
        test_timeout();
        test_restart();
        test_overflow();
        test_reset();
        test_full_pop_push();
        test_reset_in_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ik_angle_capture.md
IK_ANGLE_CAPTURE -- requirements
Module: ik_angle_capture

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32, angle word width.
REQ-002 SHALL have parameter FRACTIONS, default 15, fractional bits of the fixed-point angle format (Q17.15); carried through unchanged, never used for arithmetic.
REQ-003 SHALL have parameter STABLE_CYCLES, default 8, consecutive unchanged samples required to accept an angle pair (legal range 1..255).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum settle cycles before a forced capture (must exceed STABLE_CYCLES).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, result buffer entries (power of two).
REQ-006 SHALL have port clock, input, 1, sole clock, rising-edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port start, input, 1, pulse: a new x,y target was applied to the upstream inv_kin this cycle.
REQ-009 SHALL have ports theta1_in and theta2_in, input, BIT_WIDTH, raw joint angles from inv_kin.
REQ-010 SHALL have port out_valid, output, 1, FIFO head valid.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the head.
REQ-012 SHALL have ports out_theta1 and out_theta2, output, BIT_WIDTH, head angles.
REQ-013 SHALL have port out_timeout, output, 1, head entry was a forced (unsettled) capture.
REQ-014 SHALL have port busy, output, 1, high while in state WAIT.
REQ-015 SHALL have port overflow, output, 1, sticky: a result was dropped.

Function
REQ-016 SHALL implement a two-state FSM: IDLE and WAIT.
REQ-017 In IDLE, start SHALL load prev_t1/prev_t2 with theta1_in/theta2_in, clear stable_cnt and elapsed, and enter WAIT.
REQ-018 Each WAIT cycle SHALL increment elapsed, compare theta inputs to prev (both words, bit-exact), increment stable_cnt on match or clear it on mismatch, then reload prev.
REQ-019 A WAIT cycle whose match makes stable_cnt reach STABLE_CYCLES SHALL push {theta1_in, theta2_in, timeout=0} and return to IDLE.
REQ-020 A WAIT cycle with elapsed reaching TIMEOUT_CYCLES and no stable capture SHALL push {theta1_in, theta2_in, timeout=1} and return to IDLE; stable capture wins on the same cycle.
REQ-021 start asserted in WAIT without a capture that cycle SHALL restart the settle window (reload prev, clear counters, stay WAIT), discarding nothing from the FIFO.
REQ-022 start asserted in the same cycle as a capture SHALL complete the push and re-enter WAIT with freshly loaded prev.
REQ-023 Latency: with constant inputs and empty FIFO, start at cycle 0 SHALL yield push at cycle STABLE_CYCLES and out_valid high from cycle STABLE_CYCLES+1.
REQ-024 FIFO SHALL be first-word-fall-through; out_* reflect the head whenever out_valid=1; pop on out_valid & out_ready.
REQ-025 Push while full SHALL be dropped and set overflow, unless a pop occurs the same cycle, in which case the push SHALL succeed.
REQ-026 Push and pop in the same cycle on a non-empty FIFO SHALL leave occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-027 out_theta1/out_theta2/out_timeout SHALL be don't-care but held stable while out_valid=0.

Reset
REQ-028 rst SHALL force IDLE, busy=0, out_valid=0, overflow=0, FIFO empty, counters and prev registers 0, out_theta1=out_theta2=0, out_timeout=0.
REQ-029 rst during WAIT SHALL abandon the settle window with no push; rst overrides start, push and pop in the same cycle.

Structure
REQ-030 A shared package ik_pkg SHALL hold BIT_WIDTH/FRACTIONS defaults, the IDLE/WAIT state enum and the result entry type {theta1, theta2, timeout}.
REQ-031 The buffer SHALL be one sub-module ik_result_fifo (push/pop/full/empty, entry type from ik_pkg); the FSM and counters live in the top module.

Verification
REQ-032 Constant theta1_in=0x0000C90F, theta2_in=0x00006488, start at cycle 0 -> out_valid at cycle 9, head 0x0000C90F/0x00006488, out_timeout=0.
REQ-033 theta1_in toggles 0x1/0x2 every cycle after start -> push at elapsed=1024 with out_timeout=1, busy falls next cycle.
REQ-034 Inputs change once at cycle 5 then hold -> capture at cycle 5+8=13, not earlier.
REQ-035 out_ready=0, five settled captures with FIFO_DEPTH=4 -> four entries retained in order, fifth dropped, overflow=1 until rst.
REQ-036 Full FIFO, out_ready=1 on the cycle of a capture -> pop and push both succeed, occupancy stays 4, overflow stays 0.
REQ-037 rst asserted at cycle 4 of WAIT -> no entry ever appears, busy=0 next cycle, subsequent start behaves as REQ-032.
